serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_fa_cell.sv | 22 ++
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full-adder cell built from two half-adder stages and an OR.
module fa_cell
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p1;
    logic g1;
    logic g2;

    assign p1   = x ^ y;
    assign g1   = x & y;
    assign s    = p1 ^ cin;
    assign g2   = p1 & cin;
    assign cout = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock, start/done handshake.
// Optional subtract mode (sub input, borrow output) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             borrow,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last;
    logic             fa_s;
    logic             fa_c;

    fa_cell u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The final RUN edge publishes the fully shifted sum directly, so the
    // output register changes exactly on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            c_q       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            borrow    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh  <= a;
                cnt_q <= '0;
                s_sh  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                b_sh  <= sub ? ~b : b;
                c_q   <= sub;
`else
                b_sh  <= b;
                c_q   <= 1'b0;
`endif
            end else if (state_q == ST_RUN) begin
                s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                c_q   <= fa_c;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    sum       <= {fa_s, s_sh[WIDTH-1:1]};
                    carry_out <= fa_c;
`ifdef SERIAL_ADDER_SUB_EN
                    borrow    <= ~fa_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic       borrow;
`endif

    int         checks;
    int         failures;
    logic [7:0] last_sum;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
        .borrow    (borrow),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; pulse_at >= 0 injects an ignored start mid-RUN.
    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input logic [7:0] exp_sum, input logic exp_c,
                         input int pulse_at);
        int nb;
        logic got;
        nb  = 0;
        got = 1'b0;
        a = x; b = y; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~x; b = ~y; sub = ~s;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) check({tag, "_hold"}, 32'(sum), 32'(last_sum));
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nb++;
            start = (i == pulse_at);
            if (i == pulse_at) begin
                a = 8'hFF;
                b = 8'hFF;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
`ifdef SERIAL_ADDER_SUB_EN
        check({tag, "_borrow"}, 32'(borrow), 32'(~exp_c));
`endif
        tick();
        check({tag, "_single_pulse"}, 32'(done), 32'd0);
        check({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
        last_sum = exp_sum;
    endtask

    initial begin
        int gap;
        int ndone;
        logic got;
        checks   = 0;
        failures = 0;
        last_sum = 8'h00;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;

        // Reset
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_carry", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDER_SUB_EN
        check("rst_borrow", 32'(borrow), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Basic and wrap-around
        do_op("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, -1);
        do_op("wrap1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        do_op("wrapff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, -1);

        // Start mid-RUN ignored
        do_op("midstart", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
        check("midstart_idle", 32'(busy), 32'd0);

        // Back-to-back with start held through DONE
        a = 8'h01; b = 8'h02; start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_first_done", 32'(got), 32'd1);
        check("b2b_first_sum", 32'(sum), 32'h03);
        a = 8'h0F; b = 8'h10;
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            gap++;
            if (i == 0) begin
                check("b2b_no_idle", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_second_done", 32'(got), 32'd1);
        check("b2b_gap", 32'(gap), 32'd9);
        check("b2b_second_sum", 32'(sum), 32'h1F);
        check("b2b_second_carry", 32'(carry_out), 32'd0);
        tick();
        last_sum = 8'h1F;

        // Reset during the 4th RUN cycle
        a = 8'h55; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'h00);
        check("abort_carry", 32'(carry_out), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        last_sum = 8'h00;
        do_op("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, -1);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract mode
        do_op("sub_pos", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, -1);
        do_op("sub_neg", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, -1);
        do_op("add_after_sub", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, -1);
        do_op("hs_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, -1);
        do_op("hs_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, -1);
        do_op("hs_10", 8'h01, 8'h00, 1'b1, 8'h01, 1'b1, -1);
        do_op("hs_11", 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
